// File: rtl/amp_pkg.sv
// Shared types and constants for the amplifier requester and its result buffer.
package amp_pkg;

    localparam int TAG_WIDTH  = 8;
    localparam int BASE_WIDTH = 8;
    localparam int RES_WIDTH  = 24;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DRAIN,
        RUN
    } state_t;

    typedef struct packed {
        logic [TAG_WIDTH-1:0] no;
        logic [RES_WIDTH-1:0] res;
    } result_t;

endpackage

// File: rtl/res_fifo.sv
// Synchronous result FIFO. Storage is not reset; pointers and count are, so
// nothing stale is ever presented as valid.
module res_fifo
    import amp_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push,
    input  result_t          push_data,
    input  logic             pop,
    output result_t          head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    result_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_pop;

    assign do_pop = pop && (cnt != '0);
    assign full   = (cnt == CNT_W'(DEPTH));
    assign empty  = (cnt == '0);
    assign count  = cnt;
    assign head   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/amp_requester.sv
// Amplifier requester: loads and verifies a scaler, then streams tagged base
// numbers to the amplifier and buffers its in-order, tag-checked results.
module amp_requester
    import amp_pkg::*;
#(
    parameter int WR_DATA_WIDTH = 16,
    parameter int RD_DATA_WIDTH = 32,
    parameter int SCALER_WIDTH  = 16,
    parameter int RES_DEPTH     = 4,
    parameter int CHK_TIMEOUT   = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     cfg_load_i,
    input  logic [SCALER_WIDTH-1:0]  cfg_scaler_i,
    input  logic                     base_val_i,
    output logic                     base_rdy_o,
    input  logic [7:0]               base_i,
    output logic                     amp_wr_en_o,
    output logic                     amp_set_scaler_o,
    output logic [WR_DATA_WIDTH-1:0] amp_wr_data_o,
    input  logic                     amp_rd_val_i,
    input  logic [RD_DATA_WIDTH-1:0] amp_rd_data_i,
    input  logic [SCALER_WIDTH-1:0]  amp_scaler_i,
    output logic                     res_val_o,
    input  logic                     res_rdy_i,
    output logic [7:0]               res_no_o,
    output logic [23:0]              res_data_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int CNT_W = $clog2(RES_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam int TMR_W = $clog2(CHK_TIMEOUT) + 1;

    state_t                  state;
    state_t                  state_next;
    logic [SCALER_WIDTH-1:0] scaler;
    logic [TAG_WIDTH-1:0]    issue_tag;
    logic [TAG_WIDTH-1:0]    expect_tag;
    logic [CNT_W-1:0]        outstanding;
    logic [TMR_W-1:0]        chk_cnt;
    logic                    err;

    logic                    load_accept;
    logic                    issue;
    logic                    rd_live;
    logic                    rd_accept;
    logic                    rd_stray;
    logic                    tag_bad;
    logic                    chk_match;
    logic                    chk_expired;
    logic [OCC_W-1:0]        occupancy;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    result_t                 fifo_head;
    result_t                 rd_result;

    // Outstanding requests plus buffered results can never exceed the buffer
    // depth, so every amplifier return is guaranteed a free slot.
    assign occupancy   = {1'b0, outstanding} + {1'b0, fifo_count};
    assign base_rdy_o  = (state == RUN) && (occupancy < OCC_W'(RES_DEPTH)) && !cfg_load_i;
    assign issue       = base_val_i && base_rdy_o;
    assign load_accept = cfg_load_i && ((state == IDLE) || (state == RUN));

    // Returns are ignored outright while the scaler is being loaded or verified.
    assign rd_live     = amp_rd_val_i && (state != LOAD) && (state != CHECK);
    assign rd_accept   = rd_live && (outstanding != '0);
    assign rd_stray    = rd_live && (outstanding == '0);
    assign rd_result   = '{no: amp_rd_data_i[31:24], res: amp_rd_data_i[23:0]};
    assign tag_bad     = rd_accept && (rd_result.no != expect_tag);

    assign chk_match   = (amp_scaler_i == scaler);
    assign chk_expired = (state == CHECK) && !chk_match && (chk_cnt == TMR_W'(CHK_TIMEOUT - 1));

    assign fifo_push   = rd_accept && (!fifo_full || fifo_pop);
    assign fifo_pop    = res_val_o && res_rdy_i;

    assign res_val_o   = !fifo_empty;
    assign res_no_o    = fifo_head.no;
    assign res_data_o  = fifo_head.res;
    assign busy_o      = (state != RUN) || (outstanding != '0);
    assign err_o       = err;

    res_fifo #(
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .push      (fifo_push),
        .push_data (rd_result),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Amplifier write port: scaler write in LOAD, tagged base on an issue, zero otherwise.
    always_comb begin
        amp_wr_en_o      = 1'b0;
        amp_set_scaler_o = 1'b0;
        amp_wr_data_o    = '0;
        if (state == LOAD) begin
            amp_wr_en_o      = 1'b1;
            amp_set_scaler_o = 1'b1;
            amp_wr_data_o    = WR_DATA_WIDTH'(scaler);
        end else if (issue) begin
            amp_wr_en_o      = 1'b1;
            amp_wr_data_o    = WR_DATA_WIDTH'({issue_tag, base_i});
        end
    end

    // Next-state logic; a load seen in RUN waits in DRAIN until all requests have returned.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (cfg_load_i) state_next = LOAD;
            LOAD:    state_next = CHECK;
            CHECK:   if (chk_match) state_next = RUN;
                     else if (chk_expired) state_next = IDLE;
            DRAIN:   if (outstanding == '0) state_next = LOAD;
            RUN:     if (cfg_load_i) state_next = DRAIN;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the scaler at the moment a load request is accepted.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            scaler <= '0;
        end else if (load_accept) begin
            scaler <= cfg_scaler_i;
        end
    end

    // Count cycles spent waiting for the amplifier to reflect the new scaler.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            chk_cnt <= '0;
        end else if (state == CHECK) begin
            chk_cnt <= chk_cnt + 1'b1;
        end else begin
            chk_cnt <= '0;
        end
    end

    // Issue and expected-return tags advance independently and wrap naturally at 8 bits.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            issue_tag  <= '0;
            expect_tag <= '0;
        end else begin
            if (issue) begin
                issue_tag <= issue_tag + 1'b1;
            end
            if (rd_accept) begin
                expect_tag <= expect_tag + 1'b1;
            end
        end
    end

    // Outstanding request count; an issue and a return in the same cycle cancel out.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            outstanding <= '0;
        end else begin
            case ({issue, rd_accept})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky error: scaler verify timeout, out-of-order tag, or a return nobody asked for.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err <= 1'b0;
        end else if (chk_expired || tag_bad || rd_stray) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_amp_requester.sv
// Bench for amp_requester: a behavioural amplifier plus a result model that
// predicts every write and every popped result from the stimulus alone.
module tb_amp_requester;

    logic        clk_i        = 1'b0;
    logic        rstn_i       = 1'b0;
    logic        cfg_load_i   = 1'b0;
    logic [15:0] cfg_scaler_i = '0;
    logic        base_val_i   = 1'b0;
    logic [7:0]  base_i       = '0;
    logic        res_rdy_i    = 1'b0;
    logic        amp_rd_val_i = 1'b0;
    logic [31:0] amp_rd_data_i = '0;
    logic [15:0] amp_scaler_i = '0;

    logic        base_rdy_o;
    logic        amp_wr_en_o;
    logic        amp_set_scaler_o;
    logic [15:0] amp_wr_data_o;
    logic        res_val_o;
    logic [7:0]  res_no_o;
    logic [23:0] res_data_o;
    logic        busy_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    // Stimulus-owned knobs
    logic [15:0] m_scaler     = '0;
    logic        amp_hold     = 1'b0;
    logic        scaler_stuck = 1'b0;

    // Model-owned state (written only by the per-cycle compare process)
    logic [7:0]  m_tag = '0;
    logic [31:0] exp_q[$];
    int          inflight = 0;
    int          n_issue = 0;
    int          n_pop = 0;
    int          n_scaler_wr = 0;
    logic [15:0] last_scaler_wr = '0;
    logic [15:0] last_issue = '0;
    logic [31:0] last_res = '0;
    logic        saw_wrap = 1'b0;
    logic        prev_valid = 1'b0;
    logic [7:0]  prev_no = '0;
    int          cyc = 0;
    logic [15:0] amp_scaler_reg = '0;
    logic [31:0] amp_data_q[$];
    int          amp_due_q[$];
    logic [31:0] prod;
    logic [31:0] amp_prod;

    amp_requester #(
        .WR_DATA_WIDTH (16),
        .RD_DATA_WIDTH (32),
        .SCALER_WIDTH  (16),
        .RES_DEPTH     (4),
        .CHK_TIMEOUT   (8)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .cfg_load_i       (cfg_load_i),
        .cfg_scaler_i     (cfg_scaler_i),
        .base_val_i       (base_val_i),
        .base_rdy_o       (base_rdy_o),
        .base_i           (base_i),
        .amp_wr_en_o      (amp_wr_en_o),
        .amp_set_scaler_o (amp_set_scaler_o),
        .amp_wr_data_o    (amp_wr_data_o),
        .amp_rd_val_i     (amp_rd_val_i),
        .amp_rd_data_i    (amp_rd_data_i),
        .amp_scaler_i     (amp_scaler_i),
        .res_val_o        (res_val_o),
        .res_rdy_i        (res_rdy_i),
        .res_no_o         (res_no_o),
        .res_data_o       (res_data_o),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Per-cycle compare against the model, then the amplifier's behaviour for the next cycle.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            exp_q.delete();
            amp_data_q.delete();
            amp_due_q.delete();
            m_tag          = '0;
            inflight       = 0;
            prev_valid     = 1'b0;
            amp_scaler_reg = '0;
            amp_scaler_i   = '0;
            amp_rd_val_i   = 1'b0;
            amp_rd_data_i  = '0;
        end else begin
            cyc++;
            if (amp_wr_en_o && amp_set_scaler_o) begin
                n_scaler_wr++;
                last_scaler_wr = amp_wr_data_o;
                check_output("scaler_write", {16'd0, amp_wr_data_o}, {16'd0, m_scaler});
                check_output("load_with_requests_pending", amp_data_q.size() + int'(amp_rd_val_i), 0);
                if (!scaler_stuck) amp_scaler_reg = amp_wr_data_o;
            end else if (amp_wr_en_o) begin
                check_output("issue_handshake", {31'd0, base_val_i && base_rdy_o}, 1);
                check_output("issue_data", {16'd0, amp_wr_data_o}, {16'd0, m_tag, base_i});
                prod     = 32'(base_i) * 32'(m_scaler);
                amp_prod = 32'(amp_wr_data_o[7:0]) * 32'(amp_scaler_reg);
                exp_q.push_back({m_tag, prod[23:0]});
                amp_data_q.push_back({amp_wr_data_o[15:8], amp_prod[23:0]});
                amp_due_q.push_back(cyc + 2);
                last_issue = amp_wr_data_o;
                m_tag      = m_tag + 8'd1;
                inflight++;
                n_issue++;
            end else begin
                check_output("quiet_write_outputs", {15'd0, amp_set_scaler_o, amp_wr_data_o}, 0);
                check_output("handshake_without_issue", {31'd0, base_val_i && base_rdy_o}, 0);
            end
            check_output("occupancy_bound", {31'd0, inflight <= 4}, 1);
            if (res_val_o) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_result", {res_no_o, res_data_o}, 32'hFFFF_FFFF);
                end else begin
                    check_output("result_head", {res_no_o, res_data_o}, exp_q[0]);
                    if (res_rdy_i) begin
                        void'(exp_q.pop_front());
                        last_res = {res_no_o, res_data_o};
                        if (prev_valid && prev_no == 8'd255 && res_no_o == 8'd0) saw_wrap = 1'b1;
                        prev_no    = res_no_o;
                        prev_valid = 1'b1;
                        inflight--;
                        n_pop++;
                    end
                end
            end
            if (!amp_hold && amp_due_q.size() > 0 && amp_due_q[0] <= cyc) begin
                amp_rd_val_i  = 1'b1;
                amp_rd_data_i = amp_data_q.pop_front();
                void'(amp_due_q.pop_front());
            end else begin
                amp_rd_val_i  = 1'b0;
                amp_rd_data_i = '0;
            end
            amp_scaler_i = scaler_stuck ? 16'd0 : amp_scaler_reg;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic apply_load(input logic [15:0] value);
        cfg_scaler_i = value;
        m_scaler     = value;
        cfg_load_i   = 1'b1;
        @(posedge clk_i);
        #1;
        cfg_load_i   = 1'b0;
    endtask

    task automatic apply_bases(input int count, input int budget, input logic [7:0] first, output int accepted);
        int   n;
        logic hs;
        accepted = 0;
        n = 0;
        while (accepted < count && n < budget) begin
            base_val_i = 1'b1;
            base_i     = 8'(first + 8'(accepted));
            @(negedge clk_i);
            hs = base_rdy_o;
            @(posedge clk_i);
            #1;
            if (hs) accepted++;
            n++;
        end
        base_val_i = 1'b0;
    endtask

    task automatic wait_not_busy(input int budget, input string name);
        int n;
        n = 0;
        while (busy_o && n < budget) begin
            wait_cycles(1);
            n++;
        end
        check_output(name, {31'd0, busy_o}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int nw;
        int np;
        int n;

        res_rdy_i = 1'b1;
        #1;
        // Reset state
        check_output("rst_busy",      {31'd0, busy_o}, 1);
        check_output("rst_base_rdy",  {31'd0, base_rdy_o}, 0);
        check_output("rst_wr_en",     {31'd0, amp_wr_en_o}, 0);
        check_output("rst_set",       {31'd0, amp_set_scaler_o}, 0);
        check_output("rst_wr_data",   {16'd0, amp_wr_data_o}, 0);
        check_output("rst_res_val",   {31'd0, res_val_o}, 0);
        check_output("rst_err",       {31'd0, err_o}, 0);
        repeat (3) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        wait_cycles(1);

        $display("[TB] load scaler 100");
        nw = n_scaler_wr;
        apply_load(16'd100);
        wait_not_busy(20, "load_reaches_run");
        check_output("load_write_count", nw + 1, n_scaler_wr);
        check_output("load_write_value", {16'd0, last_scaler_wr}, 32'd100);
        check_output("run_ready", {31'd0, base_rdy_o}, 1);
        check_output("load_err", {31'd0, err_o}, 0);

        $display("[TB] tag 5 with base 25");
        apply_bases(5, 60, 8'd1, acc);
        check_output("first_five_accepted", acc, 5);
        apply_bases(1, 20, 8'd25, acc);
        check_output("base25_accepted", acc, 1);
        check_output("tag5_write", {16'd0, last_issue}, 32'h0000_0519);
        wait_not_busy(20, "tag5_returns");
        wait_cycles(3);
        check_output("tag5_result", last_res, {8'd5, 24'd2500});

        $display("[TB] stalled result stream");
        res_rdy_i = 1'b0;
        np = n_pop;
        apply_bases(10, 40, 8'd50, acc);
        check_output("stall_accepted", acc, 4);
        check_output("stall_not_ready", {31'd0, base_rdy_o}, 0);
        check_output("stall_res_valid", {31'd0, res_val_o}, 1);
        check_output("stall_no_pops", n_pop - np, 0);
        res_rdy_i = 1'b1;
        wait_cycles(8);
        check_output("stall_drain_pops", n_pop - np, 4);
        check_output("stall_drained", {31'd0, res_val_o}, 0);

        $display("[TB] 260 requests across tag wrap");
        np = n_pop;
        apply_bases(260, 3000, 8'd0, acc);
        check_output("wrap_accepted", acc, 260);
        wait_not_busy(20, "wrap_returns");
        wait_cycles(3);
        check_output("wrap_pops", n_pop - np, 260);
        check_output("wrap_seen", {31'd0, saw_wrap}, 1);
        check_output("wrap_err", {31'd0, err_o}, 0);

        $display("[TB] load while requests outstanding");
        amp_hold = 1'b1;
        apply_bases(2, 20, 8'd7, acc);
        check_output("drain_issued", acc, 2);
        nw = n_scaler_wr;
        apply_load(16'd3);
        wait_cycles(5);
        check_output("drain_holds_load", n_scaler_wr - nw, 0);
        check_output("drain_busy", {31'd0, busy_o}, 1);
        check_output("drain_not_ready", {31'd0, base_rdy_o}, 0);
        amp_hold = 1'b0;
        n = 0;
        while (n_scaler_wr == nw && n < 20) begin
            wait_cycles(1);
            n++;
        end
        check_output("drain_then_load", n_scaler_wr - nw, 1);
        check_output("drain_load_value", {16'd0, last_scaler_wr}, 32'd3);
        wait_not_busy(20, "reload_reaches_run");
        check_output("drain_err", {31'd0, err_o}, 0);

        $display("[TB] reset in the middle of RUN");
        res_rdy_i = 1'b0;
        apply_bases(3, 20, 8'd90, acc);
        wait_cycles(4);
        check_output("pre_reset_res_valid", {31'd0, res_val_o}, 1);
        base_val_i = 1'b1;
        base_i     = 8'd33;
        #1;
        check_output("pre_reset_issue", {31'd0, amp_wr_en_o}, 1);
        rstn_i = 1'b0;
        #1;
        check_output("midrst_wr_en",    {31'd0, amp_wr_en_o}, 0);
        check_output("midrst_set",      {31'd0, amp_set_scaler_o}, 0);
        check_output("midrst_wr_data",  {16'd0, amp_wr_data_o}, 0);
        check_output("midrst_base_rdy", {31'd0, base_rdy_o}, 0);
        check_output("midrst_res_val",  {31'd0, res_val_o}, 0);
        check_output("midrst_busy",     {31'd0, busy_o}, 1);
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        wait_cycles(1);
        check_output("postrst_wr_en",   {31'd0, amp_wr_en_o}, 0);
        check_output("postrst_res_val", {31'd0, res_val_o}, 0);
        check_output("postrst_err",     {31'd0, err_o}, 0);
        base_val_i = 1'b0;
        res_rdy_i  = 1'b1;

        $display("[TB] scaler readback stuck at zero");
        scaler_stuck = 1'b1;
        nw           = n_scaler_wr;
        cfg_scaler_i = 16'd100;
        m_scaler     = 16'd100;
        cfg_load_i   = 1'b1;
        n = 0;
        do begin
            @(posedge clk_i);
            #1;
            cfg_load_i = 1'b0;
            n++;
        end while (!err_o && n < 40);
        // Edge taking the load, one LOAD cycle, then 8 unmatched CHECK cycles.
        check_output("timeout_edges", n, 10);
        check_output("timeout_load_write", n_scaler_wr - nw, 1);
        check_output("timeout_busy", {31'd0, busy_o}, 1);
        check_output("timeout_not_ready", {31'd0, base_rdy_o}, 0);
        wait_cycles(5);
        check_output("err_sticky", {31'd0, err_o}, 1);
        check_output("timeout_idle_quiet", {31'd0, amp_wr_en_o}, 0);
        rstn_i = 1'b0;
        #1;
        check_output("err_cleared_by_reset", {31'd0, err_o}, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i       = 1'b1;
        scaler_stuck = 1'b0;
        wait_cycles(2);

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/amp_requester.md
AMP_REQUESTER -- requirements
Module: amp_requester

Interface
REQ-001 SHALL have parameter WR_DATA_WIDTH, default 16: amplifier write-data width, {no[15:8], base[7:0]} or scaler value.
REQ-002 SHALL have parameter RD_DATA_WIDTH, default 32: amplifier read-data width, {no[31:24], res[23:0]}.
REQ-003 SHALL have parameter SCALER_WIDTH, default 16: scaler width.
REQ-004 SHALL have parameter RES_DEPTH, default 4: result buffer depth, power of two, minimum 2.
REQ-005 SHALL have parameter CHK_TIMEOUT, default 8: maximum number of cycles CHECK waits for the scaler readback.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port rstn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port cfg_load_i, input, 1 bit: single-cycle pulse requesting a scaler load.
REQ-009 SHALL have port cfg_scaler_i, input, SCALER_WIDTH bits: scaler value, sampled when cfg_load_i is accepted.
REQ-010 SHALL have ports base_val_i (input, 1), base_rdy_o (output, 1) and base_i (input, 8): base-number valid/ready stream.
REQ-011 SHALL have ports amp_wr_en_o (output, 1), amp_set_scaler_o (output, 1) and amp_wr_data_o (output, WR_DATA_WIDTH): amplifier write side.
REQ-012 SHALL have ports amp_rd_val_i (input, 1), amp_rd_data_i (input, RD_DATA_WIDTH) and amp_scaler_i (input, SCALER_WIDTH): amplifier return side.
REQ-013 SHALL have ports res_val_o (output, 1), res_rdy_i (input, 1), res_no_o (output, 8) and res_data_o (output, 24): result valid/ready stream.
REQ-014 SHALL have port busy_o, output, 1 bit: high in any state other than RUN, or while any request is outstanding.
REQ-015 SHALL have port err_o, output, 1 bit: sticky error flag, cleared only by reset.

Function
REQ-016 SHALL implement an FSM with states IDLE, LOAD, CHECK, DRAIN and RUN.
REQ-017 SHALL leave IDLE for LOAD on cfg_load_i; base_rdy_o SHALL be 0 in IDLE.
REQ-018 SHALL, in LOAD, drive amp_wr_en_o=1, amp_set_scaler_o=1 and amp_wr_data_o=latched scaler for exactly one cycle, then go to CHECK.
REQ-019 SHALL, in CHECK, go to RUN when amp_scaler_i equals the latched scaler; after CHK_TIMEOUT cycles without a match it SHALL set err_o and go to IDLE.
REQ-020 SHALL, in RUN, assert base_rdy_o when (outstanding + buffer occupancy) < RES_DEPTH and cfg_load_i is low.
REQ-021 SHALL, on each base handshake, drive a one-cycle write with amp_wr_en_o=1, amp_set_scaler_o=0 and amp_wr_data_o={tag, base_i}, where tag is an 8-bit counter incrementing per issue and wrapping 255->0.
REQ-022 SHALL treat cfg_load_i in RUN as a pending load: stop issuing, go to DRAIN, and leave DRAIN for LOAD once outstanding = 0.
REQ-023 SHALL keep all amplifier write outputs at 0 in every cycle that is not a LOAD or issue cycle.
REQ-024 SHALL, on amp_rd_val_i with outstanding > 0, compare amp_rd_data_i[31:24] with the expected tag (in order, wrapping); on mismatch it SHALL set err_o.
REQ-025 SHALL push every such result into the buffer regardless of the tag check, then decrement outstanding.
REQ-026 SHALL, on amp_rd_val_i with outstanding = 0, set err_o and discard the data; in LOAD and CHECK, amp_rd_val_i SHALL be ignored entirely.
REQ-027 SHALL keep the outstanding count correct when an issue and a return occur in the same cycle, and the buffer correct on simultaneous push and pop.
REQ-028 SHALL present the buffer head on res_no_o/res_data_o with res_val_o = (buffer not empty); pop occurs on res_val_o & res_rdy_i, and outputs are stable while stalled.
REQ-029 SHALL, by construction of REQ-020, never overflow the buffer, since amplifier returns cannot be back-pressured.

Reset
REQ-030 SHALL, on rstn_i low, asynchronously set: state=IDLE; all amp_* outputs, base_rdy_o, res_val_o and err_o to 0; tags, outstanding count and buffer pointers to 0; busy_o=1.
REQ-031 SHALL discard outstanding requests and buffered results on reset mid-operation, with no output glitch after release.

Structure
REQ-032 SHALL place width constants, the state enum and a result struct {no[7:0], res[23:0]} in shared package amp_pkg.
REQ-033 SHALL implement the result buffer as sub-module res_fifo (synchronous FIFO, depth RES_DEPTH, with full/empty/count).

Verification
REQ-034 SHALL cover: cfg_load_i with scaler 100 -> one set-scaler write of 16'd100, then state RUN with err_o=0.
REQ-035 SHALL cover: with scaler 100, base 25 as first request after tag reached 5 -> write 16'h0519, result no=5 res=2500.
REQ-036 SHALL cover: res_rdy_i held 0 with 10 bases offered -> exactly 4 accepted; then res_rdy_i=1 -> 4 results popped in order with no loss.
REQ-037 SHALL cover: 260 requests -> tags wrap 255->0, with all results' tags matching and err_o=0.
REQ-038 SHALL cover: amp_scaler_i stuck at 0 after load -> err_o=1 after 8 cycles, return to IDLE.
REQ-039 SHALL cover: cfg_load_i of 3 with 2 requests outstanding -> DRAIN until both return, then a set-scaler write of 3; reset asserted mid-RUN -> all outputs 0 immediately.
